rr_output_allocator: RTL and testbench

Per-output-port switch allocator for the router. It shares one output link among NR input ports using round-robin priority. Once a packet's head flit wins, the grant is locked to that input until its tail flit passes (wormhole). Every flit transfer is gated by a credit counter that tracks free slots in the downstream input buffer. One instance sits on each output port, between the input-port request logic and the crossbar select.

---
 rtl/rr_output_allocator.sv | 144 ++++++++++++++
 tb/tb_rr_output_allocator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_output_allocator.sv
// Round-robin, wormhole-locking switch allocator for one router output port.
// Every flit transfer is gated by a credit count of free downstream buffer slots.
module rr_output_allocator #(
    parameter int NR        = 5,
    parameter int BUF_DEPTH = 4,
    localparam int CW       = $clog2(BUF_DEPTH + 1),
    localparam int PW       = $clog2(NR)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [NR-1:0] REQ,
    input  logic [NR-1:0] TAIL,
    input  logic          CREDIT_IN,
    output logic [NR-1:0] GRT,
    output logic          FIRE,
    output logic [CW-1:0] CREDIT_CNT,
    output logic          LOCKED,
    output logic [PW-1:0] OWNER,
    output logic          CREDIT_ERR
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          err_q, err_d;
    logic [NR-1:0] grt_s;
    logic          fire_s;
    logic [PW:0]   pick_s;

    // Index after i, wrapping explicitly since NR need not be a power of two.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(NR - 1)) ? '0 : i + PW'(1);
    endfunction

    // Returns {found, index} of the first requester at or after ptr (circular).
    // Scanning from the far end lets the closest requester overwrite the result last.
    function automatic logic [PW:0] rr_pick(input logic [NR-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0] sum;
        logic [PW:0] res;
        res = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW + 1)'(k);
            sum = (sum >= (PW + 1)'(NR)) ? sum - (PW + 1)'(NR) : sum;
            res = req[sum[PW-1:0]] ? {1'b1, sum[PW-1:0]} : res;
        end
        return res;
    endfunction

    assign pick_s = rr_pick(REQ, ptr_q);

    // Grant selection and mode/owner/pointer next-state.
    always_comb begin
        grt_s   = '0;
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if ((credit_q != '0) && pick_s[PW]) begin
                    grt_s[pick_s[PW-1:0]] = 1'b1;
                    if (TAIL[pick_s[PW-1:0]]) begin
                        ptr_d = next_idx(pick_s[PW-1:0]);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = pick_s[PW-1:0];
                    end
                end else begin
                    grt_s = '0;
                end
            end
            ST_LOCKED: begin
                // Non-owner requests are ignored; an owner without REQ is just a bubble.
                if ((credit_q != '0) && REQ[owner_q]) begin
                    grt_s[owner_q] = 1'b1;
                    if (TAIL[owner_q]) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_idx(owner_q);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    grt_s = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fire_s = |grt_s;

    // Credit bookkeeping; an unmatched return at full count is flagged, not counted.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        case ({fire_s, CREDIT_IN})
            2'b10: begin
                credit_d = credit_q - CW'(1);
            end
            2'b01: begin
                if (credit_q == CW'(BUF_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
            default: begin
                credit_d = credit_q;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            credit_q <= CW'(BUF_DEPTH);
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign GRT        = RSTn ? grt_s : '0;
    assign FIRE       = |GRT;
    assign CREDIT_CNT = credit_q;
    assign LOCKED     = (state_q == ST_LOCKED);
    assign OWNER      = owner_q;
    assign CREDIT_ERR = err_q;

endmodule

// File: tb/tb_rr_output_allocator.sv
// Directed bench for rr_output_allocator (NR=5, BUF_DEPTH=4): inputs change 1ns after
// each rising edge, combinational grants are checked 1ns later, registered state after the edge.
module tb_rr_output_allocator;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [4:0] REQ;
    logic [4:0] TAIL;
    logic       CREDIT_IN;
    logic [4:0] GRT;
    logic       FIRE;
    logic [2:0] CREDIT_CNT;
    logic       LOCKED;
    logic [2:0] OWNER;
    logic       CREDIT_ERR;

    int vectors = 0;
    int miscompares = 0;

    rr_output_allocator #(.NR(5), .BUF_DEPTH(4)) dut (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .TAIL(TAIL), .CREDIT_IN(CREDIT_IN),
        .GRT(GRT), .FIRE(FIRE), .CREDIT_CNT(CREDIT_CNT), .LOCKED(LOCKED),
        .OWNER(OWNER), .CREDIT_ERR(CREDIT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0; REQ = 5'b11111; TAIL = 5'b11111; CREDIT_IN = 1'b0;
        #12;
        vectors++; if (GRT !== 5'b00000) begin miscompares++; $display("FAIL reset_grt: got %b expected %b", GRT, 5'b00000); end
        vectors++; if (FIRE !== 1'b0) begin miscompares++; $display("FAIL reset_fire: got %b expected 0", FIRE); end
        vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b expected 0", LOCKED); end
        vectors++; if (CREDIT_CNT !== 3'd4) begin miscompares++; $display("FAIL reset_credit: got %0d expected 4", CREDIT_CNT); end
        vectors++; if (CREDIT_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", CREDIT_ERR); end
        REQ = 5'b00000;
        RSTn = 1'b1;
        cyc();
        vectors++; if (CREDIT_CNT !== 3'd4) begin miscompares++; $display("FAIL reset_idle_credit: got %0d expected 4", CREDIT_CNT); end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_g [4];
        exp_g = '{5'b00010, 5'b00100, 5'b10000, 5'b00010};
        REQ = 5'b10110; TAIL = 5'b11111; CREDIT_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (GRT !== exp_g[i]) begin miscompares++; $display("FAIL rr_grt[%0d]: got %b expected %b", i, GRT, exp_g[i]); end
            vectors++; if (FIRE !== 1'b1) begin miscompares++; $display("FAIL rr_fire[%0d]: got %b expected 1", i, FIRE); end
            cyc();
            vectors++; if (CREDIT_CNT !== 3'd4) begin miscompares++; $display("FAIL rr_credit[%0d]: got %0d expected 4", i, CREDIT_CNT); end
        end
        vectors++; if (CREDIT_ERR !== 1'b0) begin miscompares++; $display("FAIL rr_err: got %b expected 0", CREDIT_ERR); end
        REQ = 5'b00000; TAIL = 5'b00000; CREDIT_IN = 1'b0;
    endtask

    // Pointer is 2 here: input 3 wins, then its tail moves the pointer to 4.
    task automatic test_wormhole();
        logic [4:0] tails [3];
        tails = '{5'b00000, 5'b00000, 5'b01000};
        REQ = 5'b01001; CREDIT_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            TAIL = tails[i];
            #1;
            vectors++; if (GRT !== 5'b01000) begin miscompares++; $display("FAIL worm_grt[%0d]: got %b expected %b", i, GRT, 5'b01000); end
            cyc();
            if (i < 2) begin
                vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL worm_locked[%0d]: got %b expected 1", i, LOCKED); end
                vectors++; if (OWNER !== 3'd3) begin miscompares++; $display("FAIL worm_owner[%0d]: got %0d expected 3", i, OWNER); end
            end else begin
                vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL worm_release: got %b expected 0", LOCKED); end
            end
        end
        // Input 3 still asks; with the pointer at 4 input 0 must win.
        TAIL = 5'b01001;
        #1;
        vectors++; if (GRT !== 5'b00001) begin miscompares++; $display("FAIL worm_next_grt: got %b expected %b", GRT, 5'b00001); end
        cyc();
        vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL worm_next_locked: got %b expected 0", LOCKED); end
        vectors++; if (CREDIT_CNT !== 3'd4) begin miscompares++; $display("FAIL worm_credit: got %0d expected 4", CREDIT_CNT); end
        REQ = 5'b00000; TAIL = 5'b00000; CREDIT_IN = 1'b0;
    endtask

    // Pointer is 1 here: input 2 wins over input 4.
    task automatic test_lock_bubble();
        REQ = 5'b10100; TAIL = 5'b00000; CREDIT_IN = 1'b0;
        #1;
        vectors++; if (GRT !== 5'b00100) begin miscompares++; $display("FAIL bub_head_grt: got %b expected %b", GRT, 5'b00100); end
        cyc();
        vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL bub_locked: got %b expected 1", LOCKED); end
        vectors++; if (OWNER !== 3'd2) begin miscompares++; $display("FAIL bub_owner: got %0d expected 2", OWNER); end
        vectors++; if (CREDIT_CNT !== 3'd3) begin miscompares++; $display("FAIL bub_credit: got %0d expected 3", CREDIT_CNT); end
        for (int i = 0; i < 2; i++) begin
            REQ = 5'b11011;
            #1;
            vectors++; if (GRT !== 5'b00000) begin miscompares++; $display("FAIL bub_gap_grt[%0d]: got %b expected %b", i, GRT, 5'b00000); end
            vectors++; if (FIRE !== 1'b0) begin miscompares++; $display("FAIL bub_gap_fire[%0d]: got %b expected 0", i, FIRE); end
            cyc();
            vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL bub_gap_locked[%0d]: got %b expected 1", i, LOCKED); end
            vectors++; if (OWNER !== 3'd2) begin miscompares++; $display("FAIL bub_gap_owner[%0d]: got %0d expected 2", i, OWNER); end
        end
        REQ = 5'b11111; TAIL = 5'b00100;
        #1;
        vectors++; if (GRT !== 5'b00100) begin miscompares++; $display("FAIL bub_resume_grt: got %b expected %b", GRT, 5'b00100); end
        cyc();
        vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL bub_release: got %b expected 0", LOCKED); end
        vectors++; if (CREDIT_CNT !== 3'd2) begin miscompares++; $display("FAIL bub_credit_end: got %0d expected 2", CREDIT_CNT); end
        REQ = 5'b00000; TAIL = 5'b00000; CREDIT_IN = 1'b1;
        cyc();
        cyc();
        CREDIT_IN = 1'b0;
        vectors++; if (CREDIT_CNT !== 3'd4) begin miscompares++; $display("FAIL bub_refill: got %0d expected 4", CREDIT_CNT); end
    endtask

    task automatic test_credit_exhaust();
        REQ = 5'b00001; TAIL = 5'b00000; CREDIT_IN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (GRT !== 5'b00001) begin miscompares++; $display("FAIL cr_grt[%0d]: got %b expected %b", i, GRT, 5'b00001); end
            cyc();
            vectors++; if (CREDIT_CNT !== 3'(3 - i)) begin miscompares++; $display("FAIL cr_cnt[%0d]: got %0d expected %0d", i, CREDIT_CNT, 3 - i); end
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (GRT !== 5'b00000) begin miscompares++; $display("FAIL cr_starve_grt[%0d]: got %b expected %b", i, GRT, 5'b00000); end
            cyc();
            vectors++; if (CREDIT_CNT !== 3'd0) begin miscompares++; $display("FAIL cr_starve_cnt[%0d]: got %0d expected 0", i, CREDIT_CNT); end
            vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL cr_starve_locked[%0d]: got %b expected 1", i, LOCKED); end
        end
        CREDIT_IN = 1'b1;
        #1;
        vectors++; if (GRT !== 5'b00000) begin miscompares++; $display("FAIL cr_pulse_grt: got %b expected %b", GRT, 5'b00000); end
        cyc();
        CREDIT_IN = 1'b0;
        vectors++; if (CREDIT_CNT !== 3'd1) begin miscompares++; $display("FAIL cr_pulse_cnt: got %0d expected 1", CREDIT_CNT); end
        #1;
        vectors++; if (GRT !== 5'b00001) begin miscompares++; $display("FAIL cr_one_grt: got %b expected %b", GRT, 5'b00001); end
        cyc();
        vectors++; if (CREDIT_CNT !== 3'd0) begin miscompares++; $display("FAIL cr_one_cnt: got %0d expected 0", CREDIT_CNT); end
        #1;
        vectors++; if (GRT !== 5'b00000) begin miscompares++; $display("FAIL cr_after_one_grt: got %b expected %b", GRT, 5'b00000); end
        CREDIT_IN = 1'b1;
        cyc();
        vectors++; if (CREDIT_CNT !== 3'd1) begin miscompares++; $display("FAIL cr_pulse2_cnt: got %0d expected 1", CREDIT_CNT); end
        TAIL = 5'b00001;
        #1;
        vectors++; if (GRT !== 5'b00001) begin miscompares++; $display("FAIL cr_tail_grt: got %b expected %b", GRT, 5'b00001); end
        cyc();
        vectors++; if (CREDIT_CNT !== 3'd1) begin miscompares++; $display("FAIL cr_fire_and_credit: got %0d expected 1", CREDIT_CNT); end
        vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL cr_tail_release: got %b expected 0", LOCKED); end
        REQ = 5'b00000; TAIL = 5'b00000;
        repeat (3) cyc();
        CREDIT_IN = 1'b0;
        vectors++; if (CREDIT_CNT !== 3'd4) begin miscompares++; $display("FAIL cr_refill: got %0d expected 4", CREDIT_CNT); end
        vectors++; if (CREDIT_ERR !== 1'b0) begin miscompares++; $display("FAIL cr_err: got %b expected 0", CREDIT_ERR); end
    endtask

    task automatic test_overflow();
        REQ = 5'b00000; TAIL = 5'b00000; CREDIT_IN = 1'b0;
        RSTn = 1'b0;
        #2;
        RSTn = 1'b1;
        CREDIT_IN = 1'b1;
        cyc();
        CREDIT_IN = 1'b0;
        vectors++; if (CREDIT_CNT !== 3'd4) begin miscompares++; $display("FAIL ovf_cnt: got %0d expected 4", CREDIT_CNT); end
        vectors++; if (CREDIT_ERR !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got %b expected 1", CREDIT_ERR); end
        repeat (3) cyc();
        vectors++; if (CREDIT_ERR !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", CREDIT_ERR); end
    endtask

    task automatic test_async_reset();
        REQ = 5'b01000; TAIL = 5'b00000; CREDIT_IN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (GRT !== 5'b01000) begin miscompares++; $display("FAIL ar_grt[%0d]: got %b expected %b", i, GRT, 5'b01000); end
            cyc();
        end
        vectors++; if (LOCKED !== 1'b1) begin miscompares++; $display("FAIL ar_locked: got %b expected 1", LOCKED); end
        vectors++; if (OWNER !== 3'd3) begin miscompares++; $display("FAIL ar_owner: got %0d expected 3", OWNER); end
        vectors++; if (CREDIT_CNT !== 3'd1) begin miscompares++; $display("FAIL ar_cnt: got %0d expected 1", CREDIT_CNT); end
        #1;
        vectors++; if (GRT !== 5'b01000) begin miscompares++; $display("FAIL ar_pre_grt: got %b expected %b", GRT, 5'b01000); end
        #2;
        RSTn = 1'b0;
        #1;
        vectors++; if (GRT !== 5'b00000) begin miscompares++; $display("FAIL ar_in_reset_grt: got %b expected %b", GRT, 5'b00000); end
        vectors++; if (FIRE !== 1'b0) begin miscompares++; $display("FAIL ar_in_reset_fire: got %b expected 0", FIRE); end
        vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL ar_in_reset_locked: got %b expected 0", LOCKED); end
        vectors++; if (CREDIT_CNT !== 3'd4) begin miscompares++; $display("FAIL ar_in_reset_cnt: got %0d expected 4", CREDIT_CNT); end
        vectors++; if (CREDIT_ERR !== 1'b0) begin miscompares++; $display("FAIL ar_in_reset_err: got %b expected 0", CREDIT_ERR); end
        REQ = 5'b11111; TAIL = 5'b11111;
        #1;
        RSTn = 1'b1;
        #1;
        vectors++; if (GRT !== 5'b00001) begin miscompares++; $display("FAIL ar_first_grt: got %b expected %b", GRT, 5'b00001); end
        cyc();
        vectors++; if (LOCKED !== 1'b0) begin miscompares++; $display("FAIL ar_after_locked: got %b expected 0", LOCKED); end
        vectors++; if (CREDIT_CNT !== 3'd3) begin miscompares++; $display("FAIL ar_after_cnt: got %0d expected 3", CREDIT_CNT); end
        REQ = 5'b00000; TAIL = 5'b00000;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wormhole();
        test_lock_bubble();
        test_credit_exhaust();
        test_overflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
